// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD frame-buffer side of the display.
package lcd_pkg;
  localparam int TFT_H      = 800;
  localparam int TFT_V      = 480;
  localparam int COORD_W    = 11;
  localparam int DEF_ADDR_W = 16;

  // One extra bit so x+w and y+h never wrap before clipping.
  typedef logic [COORD_W:0] crd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BLANK,
    ST_RUN,
    ST_DONE
  } fb_state_e;
endpackage

// File: rtl/lcd_rect_clip.sv
// Clips a rectangle to an IMG_W x IMG_H image; exclusive end coordinates.
module lcd_rect_clip
  import lcd_pkg::*;
#(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  output logic               empty_o,
  output crd_t               x_end_o,
  output crd_t               y_end_o
);
  localparam crd_t W_LIM = crd_t'(IMG_W);
  localparam crd_t H_LIM = crd_t'(IMG_H);

  crd_t x_sum, y_sum;

  assign x_sum   = {1'b0, x_i} + {1'b0, w_i};
  assign y_sum   = {1'b0, y_i} + {1'b0, h_i};
  assign x_end_o = (x_sum > W_LIM) ? W_LIM : x_sum;
  assign y_end_o = (y_sum > H_LIM) ? H_LIM : y_sum;
  assign empty_o = ({1'b0, x_i} >= W_LIM) || ({1'b0, y_i} >= H_LIM) ||
                   (w_i == '0) || (h_i == '0);
endmodule

// File: rtl/lcd_fb_writer.sv
// Rectangle-fill engine: clips a command and streams one frame-buffer write per clock.
module lcd_fb_writer
  import lcd_pkg::*;
#(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int PIX_W  = 16,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rest_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [PIX_W-1:0]   cmd_color,
  input  logic               cmd_vsync,
  input  logic               blank,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [PIX_W-1:0]   fb_wdata,
  output logic               busy,
  output logic               done
);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  fb_state_e         state_q;
  crd_t              x0_q, x_end_q, y_end_q, cx_q, cy_q;
  logic [ADDR_W-1:0] row_base_q, row_base_init;
  logic [PIX_W-1:0]  color_q;
  logic              cmd_ready_q, fb_we_q, busy_q, done_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [PIX_W-1:0]  fb_wdata_q;
  logic              clip_empty;
  crd_t              clip_x_end, clip_y_end;

  lcd_rect_clip #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_clip (
    .x_i     (cmd_x),
    .y_i     (cmd_y),
    .w_i     (cmd_w),
    .h_i     (cmd_h),
    .empty_o (clip_empty),
    .x_end_o (clip_x_end),
    .y_end_o (clip_y_end)
  );

  // Only multiply in the block: once per command, then rows accumulate.
  assign row_base_init = ADDR_W'(cmd_y * IMG_W);

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      row_base_q  <= '0;
      color_q     <= '0;
      cmd_ready_q <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fb_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            x0_q        <= {1'b0, cmd_x};
            cx_q        <= {1'b0, cmd_x};
            cy_q        <= {1'b0, cmd_y};
            x_end_q     <= clip_x_end;
            y_end_q     <= clip_y_end;
            row_base_q  <= row_base_init;
            color_q     <= cmd_color;
            if (clip_empty)     state_q <= ST_DONE;
            else if (cmd_vsync) state_q <= ST_WAIT_BLANK;
            else                state_q <= ST_RUN;
          end
        end
        ST_WAIT_BLANK: begin
          if (blank) state_q <= ST_RUN;
        end
        ST_RUN: begin
          fb_we_q    <= 1'b1;
          fb_addr_q  <= row_base_q + ADDR_W'(cx_q);
          fb_wdata_q <= color_q;
          if (cx_q == x_end_q - crd_t'(1)) begin
            cx_q       <= x0_q;
            cy_q       <= cy_q + crd_t'(1);
            row_base_q <= row_base_q + ROW_STEP;
            if (cy_q == y_end_q - crd_t'(1)) state_q <= ST_DONE;
          end else begin
            cx_q <= cx_q + crd_t'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed fills with a write scoreboard; a negedge monitor pops expected writes.
module tb_lcd_fb_writer;
  logic        clk, rest_n, cmd_valid, cmd_ready, cmd_vsync, blank;
  logic [10:0] cmd_x, cmd_y, cmd_w, cmd_h;
  logic [15:0] cmd_color;
  logic        fb_we, busy, done;
  logic [15:0] fb_addr, fb_wdata;

  lcd_fb_writer #(.IMG_W(100), .IMG_H(100), .PIX_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rest_n(rest_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_vsync(cmd_vsync), .blank(blank),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int wr_base = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int addr, input logic [15:0] data);
    exp_addr_q.push_back(16'(addr));
    exp_data_q.push_back(data);
  endtask

  always @(negedge clk) begin
    if (rest_n === 1'b1 && fb_we === 1'b1) begin
      wr_cnt++;
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h expected none", fb_addr, fb_wdata);
      end else begin
        chk("wr_addr", 32'(fb_addr), 32'(exp_addr_q.pop_front()));
        chk("wr_data", 32'(fb_wdata), 32'(exp_data_q.pop_front()));
      end
    end
  end

  task automatic accept(input int x, input int y, input int w, input int h,
                        input logic [15:0] col, input logic vs);
    int t = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_x = 11'(x); cmd_y = 11'(y); cmd_w = 11'(w); cmd_h = 11'(h);
    cmd_color = col; cmd_vsync = vs; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wr_base = wr_cnt;
  endtask

  // Counts edges from the current point until done is seen (bounded).
  task automatic wait_done(input int exp_lat, input int exp_wr, input string nm);
    int c = 0;
    bit got = 0;
    while (c < 20000 && !got) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      #1;
      if (done === 1'b1) got = 1;
    end
    chk({nm, "_done_latency"}, 32'(c), 32'(exp_lat));
    chk({nm, "_write_count"}, 32'(wr_cnt - wr_base), 32'(exp_wr));
    chk({nm, "_we_low_at_done"}, 32'(fb_we), 32'd0);
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({nm, "_scoreboard_empty"}, 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({nm, "_ready_after"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rest_n = 1'b0; cmd_valid = 1'b0; cmd_vsync = 1'b0; blank = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rest_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // Full frame
    for (int yy = 0; yy < 100; yy++)
      for (int xx = 0; xx < 100; xx++) push(yy * 100 + xx, 16'hF800);
    accept(0, 0, 100, 100, 16'hF800, 1'b0);
    wait_done(10001, 10000, "full");

    // Interior rectangle
    push(2010, 16'h07E0); push(2011, 16'h07E0); push(2012, 16'h07E0);
    push(2110, 16'h07E0); push(2111, 16'h07E0); push(2112, 16'h07E0);
    accept(10, 20, 3, 2, 16'h07E0, 1'b0);
    wait_done(7, 6, "interior");

    // Clipped at bottom-right corner
    push(9998, 16'h001F); push(9999, 16'h001F);
    accept(98, 99, 5, 5, 16'h001F, 1'b0);
    wait_done(3, 2, "clip");

    // Empty commands
    accept(100, 0, 4, 1, 16'h1111, 1'b0);
    wait_done(1, 0, "empty_x");
    accept(5, 5, 0, 3, 16'h2222, 1'b0);
    wait_done(1, 0, "empty_w");

    // Vsync hold-off
    push(0, 16'hABCD); push(1, 16'hABCD);
    blank = 1'b0;
    accept(0, 0, 2, 1, 16'hABCD, 1'b1);
    repeat (50) @(negedge clk);
    #1;
    chk("vsync_no_early_writes", 32'(wr_cnt - wr_base), 32'd0);
    chk("vsync_busy_waiting", 32'(busy), 32'd1);
    blank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("vsync_we_at_B", 32'(fb_we), 32'd0);
    blank = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("vsync_we_at_B1", 32'(fb_we), 32'd1);
    wait_done(2, 2, "vsync");

    // Reset in the middle of a run
    for (int i = 0; i < 5; i++) push(i, 16'h1234);
    accept(0, 0, 100, 100, 16'h1234, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_writes_before", 32'(wr_cnt - wr_base), 32'd5);
    #1 rest_n = 1'b0;
    #1;
    chk("midrst_we_async", 32'(fb_we), 32'd0);
    chk("midrst_busy_async", 32'(busy), 32'd0);
    chk("midrst_ready_async", 32'(cmd_ready), 32'd0);
    chk("midrst_addr_async", 32'(fb_addr), 32'd0);
    repeat (3) @(negedge clk);
    rest_n = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    chk("midrst_no_resume", 32'(wr_cnt - wr_base), 32'd5);
    chk("midrst_ready_after", 32'(cmd_ready), 32'd1);
    chk("midrst_busy_after", 32'(busy), 32'd0);
    chk("midrst_scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_fb_writer.md
# lcd_fb_writer

Rectangle-fill engine that writes the IMG_W×IMG_H frame buffer which the LCD timing generator scans out. It accepts one fill command at a time over a valid/ready handshake and clips the rectangle to the image. It then issues one buffer write per clock, at linear address `x + y*IMG_W`. It can optionally hold off until the display is in blanking, so clock-digit redraws do not tear.

## Interface
Parameters:
- `IMG_W`, default 100: image width in pixels; must match the scan-out side.
- `IMG_H`, default 100: image height in pixels.
- `PIX_W`, default 16: pixel width (RGB565).
- `ADDR_W`, default 16: frame-buffer address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: pixel/system clock.
- `rest_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle, command will be accepted.
- `cmd_x`, `cmd_y` in 11: top-left corner.
- `cmd_w`, `cmd_h` in 11: width and height in pixels.
- `cmd_color` in PIX_W: fill colour.
- `cmd_vsync` in 1: wait for `blank` before writing.
- `blank` in 1: high while the display is outside the active area (integrator-supplied).
- `fb_we` out 1: write strobe.
- `fb_addr` out ADDR_W: write address.
- `fb_wdata` out PIX_W: write data.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at command completion.

## Operation
- FSM states: IDLE, WAIT_BLANK, RUN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid & cmd_ready`, latch the command and compute the clipped bounds.
  - Go to DONE if the rectangle is empty.
  - Otherwise go to WAIT_BLANK if `cmd_vsync`=1, else RUN.
- Clipping, computed at 12 bits:
  - Empty when `cmd_x>=IMG_W`, `cmd_y>=IMG_H`, `cmd_w==0` or `cmd_h==0`.
  - `x_end=min(cmd_x+cmd_w, IMG_W)` and `y_end=min(cmd_y+cmd_h, IMG_H)`, both exclusive.
- WAIT_BLANK: stay until `blank` is sampled 1, then go to RUN. `blank` is ignored once RUN is entered.
- RUN: one write per cycle, row-major, no bubbles.
  - Counters `cx`/`cy` start at `cmd_x`/`cmd_y`.
  - `row_base` starts at `cmd_y*IMG_W`, computed once at accept, and is then accumulated by `+IMG_W` per row. There is no per-pixel multiplier.
  - `fb_addr=row_base+cx`, truncated to ADDR_W. `fb_wdata=cmd_color`.
  - When `cx==x_end-1`: `cx<=cmd_x`, `cy<=cy+1`. The pixel at `cy==y_end-1` is the last one, after which the FSM goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Commands presented while `cmd_ready`=0 are not accepted. The upstream block holds them stable.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=0 while `rest_n`=0, then 1 from the first edge after release; `fb_we`=0, `fb_addr`=0, `fb_wdata`=0, `busy`=0, `done`=0. State=IDLE.
- Command accepted at edge N with P clipped pixels (no vsync):
  - `fb_we` is high after edges N+1 … N+P.
  - `done` is high after edge N+P+1, with `fb_we` low in the same cycle.
  - `cmd_ready` is high again after edge N+P+2.
- Empty command: no writes; `done` high after edge N+1.
- Vsync wait: if `blank` is sampled high at edge B, the first write is visible after edge B+1.
- `busy` is high from edge N through the `done` cycle inclusive.
- Reset asserted mid-RUN clears all outputs immediately (asynchronously). The command is discarded; no writes resume after release.

## Structure
- Shared package `lcd_pkg`: TFT_H=800, TFT_V=480, COORD_W=11, ADDR_W default, and the FSM state enum.
- Sub-module `lcd_rect_clip`: combinational; produces the empty flag, `x_end` and `y_end` from the command and IMG_W/IMG_H. It is reusable by a future blit engine.

## Test plan
- Full frame (x=0, y=0, w=100, h=100, colour 16'hF800): exactly 10000 consecutive writes, addresses 0…9999, then one `done`.
- Interior rectangle (x=10, y=20, w=3, h=2): addresses 2010, 2011, 2012, 2110, 2111, 2112 on six consecutive cycles; `done` on the next cycle.
- Clip (x=98, y=99, w=5, h=5): only addresses 9998 and 9999 are written.
- Empty (x=100, w=4; then w=0): no `fb_we`; `done` one cycle after accept; `cmd_ready` high again the cycle after that.
- Vsync (`cmd_vsync`=1, `blank`=0 for 50 cycles, then 1): no writes while waiting; first write one cycle after `blank` is sampled high.
- Reset mid-run (`rest_n` low after 5 of 100 writes): `fb_we` drops without waiting for an edge. After release, `cmd_ready`=1 and no further writes occur.
